stopwatch_control_fsm: RTL and testbench

//   Sequences the stopwatch counter chain and SPI display driver from two raw push-buttons.

---
 rtl/stopwatch_control_fsm.sv | 219 +++++++++++++++++++++
 tb/tb_stopwatch_control_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_control_fsm.sv
// Stopwatch control: two raw push-buttons are synchronised, debounced and
// turned into single-cycle press events. Those events drive the run/stop/lap
// sequencer, which controls the counter chain and the SPI display driver.
`timescale 1ns/1ps

// Button front end: 2-FF synchroniser, debounce filter, press-edge detector.
// A button held through reset is ignored until it has been seen released.
module stopwatch_btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic res,
   input  logic i_btn,
   output logic o_press
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_settle;
   logic             r_armed;
   logic             r_press;

   // Two-stage synchroniser for the asynchronous button input.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after it has differed from the stable value
   // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else if (r_sync2 == r_stable) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST_CNT) begin
         r_stable <= r_sync2;
         r_cnt    <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Arm the press detector once the synchroniser output is valid after
   // reset and shows the button released. This keeps a button held across
   // reset from firing when the stable level catches up with it.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_settle <= 2'd0;
         r_armed  <= 1'b0;
      end else if (r_settle != 2'd2) begin
         r_settle <= r_settle + 2'd1;
      end else if (!r_sync2) begin
         r_armed <= 1'b1;
      end
   end

   // One-cycle registered pulse on a stable 0->1 transition; releases are ignored.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_stable_d <= 1'b0;
         r_press    <= 1'b0;
      end else begin
         r_stable_d <= r_stable;
         r_press    <= r_stable & ~r_stable_d & r_armed;
      end
   end

   assign o_press = r_press;

endmodule

// Run/stop/lap sequencer.
//   state    | code | cnt/disp | meaning
//   IDLE     | 000  |  0/1     | cleared, waiting for start
//   RUN      | 001  |  1/1     | counting, display live
//   LAP      | 010  |  1/0     | counting, display frozen on lap time
//   LAP_STOP | 011  |  0/0     | stopped while a lap time is displayed
//   STOP     | 100  |  0/1     | stopped, display shows stopped value
module stopwatch_control_fsm #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       res,
   input  logic       start_stop,
   input  logic       lap_time,
   output logic       counter_enable,
   output logic       display_enable,
   output logic       counter_clear,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_RUN      = 3'b001,
      ST_LAP      = 3'b010,
      ST_LAP_STOP = 3'b011,
      ST_STOP     = 3'b100
   } state_t;

   logic   w_start_press;
   logic   w_lap_press;
   state_t r_state;
   logic   r_cnt_en;
   logic   r_disp_en;
   logic   r_clear;

   stopwatch_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_start (
      .clk     (clk),
      .res     (res),
      .i_btn   (start_stop),
      .o_press (w_start_press)
   );

   stopwatch_btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_db_lap (
      .clk     (clk),
      .res     (res),
      .i_btn   (lap_time),
      .o_press (w_lap_press)
   );

   // Sequencer with registered outputs; start wins over a simultaneous lap
   // press, and the dropped lap press is not remembered.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state   <= ST_IDLE;
         r_cnt_en  <= 1'b0;
         r_disp_en <= 1'b1;
         r_clear   <= 1'b0;
      end else begin
         r_clear <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start_press) begin
                  r_state   <= ST_RUN;
                  r_cnt_en  <= 1'b1;
                  r_disp_en <= 1'b1;
               end
            end
            ST_RUN: begin
               if (w_start_press) begin
                  r_state   <= ST_STOP;
                  r_cnt_en  <= 1'b0;
                  r_disp_en <= 1'b1;
               end else if (w_lap_press) begin
                  r_state   <= ST_LAP;
                  r_cnt_en  <= 1'b1;
                  r_disp_en <= 1'b0;
               end
            end
            ST_LAP: begin
               if (w_start_press) begin
                  r_state   <= ST_LAP_STOP;
                  r_cnt_en  <= 1'b0;
                  r_disp_en <= 1'b0;
               end else if (w_lap_press) begin
                  r_state   <= ST_RUN;
                  r_cnt_en  <= 1'b1;
                  r_disp_en <= 1'b1;
               end
            end
            ST_LAP_STOP: begin
               if (w_start_press) begin
                  r_state   <= ST_LAP;
                  r_cnt_en  <= 1'b1;
                  r_disp_en <= 1'b0;
               end else if (w_lap_press) begin
                  r_state   <= ST_STOP;
                  r_cnt_en  <= 1'b0;
                  r_disp_en <= 1'b1;
               end
            end
            ST_STOP: begin
               if (w_start_press) begin
                  r_state   <= ST_RUN;
                  r_cnt_en  <= 1'b1;
                  r_disp_en <= 1'b1;
               end else if (w_lap_press) begin
                  // Clear pulse coincides with the first IDLE cycle.
                  r_state   <= ST_IDLE;
                  r_cnt_en  <= 1'b0;
                  r_disp_en <= 1'b1;
                  r_clear   <= 1'b1;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               r_cnt_en  <= 1'b0;
               r_disp_en <= 1'b1;
            end
         endcase
      end
   end

   assign state          = r_state;
   assign counter_enable = r_cnt_en;
   assign display_enable = r_disp_en;
   assign counter_clear  = r_clear;

endmodule

// File: tb/tb_stopwatch_control_fsm.sv
// Bench for the stopwatch control sequencer: directed scenarios followed by
// random button activity, checked against a table-driven model of the UI.
`timescale 1ns/1ps

module tb_stopwatch_control_fsm;

   localparam int D = 4;

   logic       clk;
   logic       res;
   logic       start_stop;
   logic       lap_time;
   logic       counter_enable;
   logic       display_enable;
   logic       counter_clear;
   logic [2:0] state;

   int n_pass  = 0;
   int n_total = 0;
   int m_state = 0;

   // Model: state index equals the displayed code (IDLE,RUN,LAP,LAP_STOP,STOP).
   int nxt_s [5] = '{1, 4, 3, 2, 1};
   int nxt_l [5] = '{0, 2, 1, 4, 0};
   int ce_t  [5] = '{0, 1, 1, 0, 0};
   int de_t  [5] = '{1, 1, 0, 0, 1};

   stopwatch_control_fsm #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (4)
   ) dut (
      .clk            (clk),
      .res            (res),
      .start_stop     (start_stop),
      .lap_time       (lap_time),
      .counter_enable (counter_enable),
      .display_enable (display_enable),
      .counter_clear  (counter_clear),
      .state          (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input int st, input int clr);
      check({tag, " state"}, {5'd0, state}, 8'(st));
      check({tag, " cnt_en"}, {7'd0, counter_enable}, 8'(ce_t[st]));
      check({tag, " disp_en"}, {7'd0, display_enable}, 8'(de_t[st]));
      check({tag, " clear"}, {7'd0, counter_clear}, 8'(clr));
   endtask

   // Hold the selected buttons for 'hold' cycles, then release for 'gap'
   // cycles. A hold of D or more is a press; the response is due exactly
   // D+3 edges after the first edge that samples the button high.
   task automatic press_seq(input bit s, input bit l, input int hold, input int gap,
                            input string tag);
      int  old_st;
      int  new_st;
      int  clr;
      bit  accepted;
      old_st   = m_state;
      accepted = (hold >= D);
      new_st   = old_st;
      clr      = 0;
      if (accepted && s)
         new_st = nxt_s[old_st];
      else if (accepted && l) begin
         new_st = nxt_l[old_st];
         clr    = (old_st == 4) ? 1 : 0;
      end
      start_stop = s;
      lap_time   = l;
      for (int j = 0; j < hold + gap; j++) begin
         tick();
         if (j == D + 2)
            check({tag, " pre"}, {5'd0, state}, 8'(old_st));
         if (j == D + 3)
            check_outputs({tag, " edge"}, new_st, clr);
         if (j == D + 4)
            check({tag, " clr_end"}, {7'd0, counter_clear}, 8'd0);
         if (j == hold - 1) begin
            start_stop = 1'b0;
            lap_time   = 1'b0;
         end
      end
      check({tag, " settled"}, {5'd0, state}, 8'(new_st));
      m_state = new_st;
   endtask

   initial begin
      res        = 1'b0;
      start_stop = 1'b0;
      lap_time   = 1'b0;
      repeat (3) tick();
      check_outputs("reset held", 0, 0);
      res = 1'b1;
      repeat (5) tick();
      check_outputs("after reset", 0, 0);

      // Long press: exactly one transition to RUN.
      press_seq(1'b1, 1'b0, 20, D + 6, "start long");
      // Short bounces in RUN are filtered.
      press_seq(1'b1, 1'b0, 3, D + 6, "glitch1");
      press_seq(1'b1, 1'b0, 3, D + 6, "glitch2");
      press_seq(1'b1, 1'b0, D + 2, D + 6, "run->stop");
      press_seq(1'b1, 1'b0, D + 2, D + 6, "stop->run");
      press_seq(1'b0, 1'b1, D + 2, D + 6, "run->lap");
      press_seq(1'b1, 1'b0, D + 2, D + 6, "lap->lapstop");
      press_seq(1'b0, 1'b1, D + 2, D + 6, "lapstop->stop");
      press_seq(1'b0, 1'b1, D + 2, D + 6, "stop->idle");
      press_seq(1'b0, 1'b1, D + 2, D + 6, "idle lap");
      press_seq(1'b1, 1'b0, D + 2, D + 6, "idle->run");
      press_seq(1'b1, 1'b1, D + 2, D + 6, "both in run");
      press_seq(1'b1, 1'b0, D + 2, D + 6, "stop->run2");
      press_seq(1'b0, 1'b1, D + 2, D + 6, "run->lap2");

      // Reset while start_stop is mid-debounce in LAP, button held throughout.
      start_stop = 1'b1;
      tick();
      tick();
      res = 1'b0;
      #1;
      check_outputs("async reset", 0, 0);
      repeat (3) tick();
      res = 1'b1;
      m_state = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i % 10 == 9)
            check("held through reset", {5'd0, state}, 8'd0);
      end
      start_stop = 1'b0;
      repeat (D + 6) tick();
      check("released after reset", {5'd0, state}, 8'd0);
      press_seq(1'b1, 1'b0, D + 1, D + 6, "repress");

      // Random button activity against the model.
      for (int n = 0; n < 60; n++) begin
         int sel;
         int hold;
         int gap;
         sel  = $urandom_range(0, 9);
         hold = $urandom_range(D, D + 8);
         gap  = $urandom_range(D + 5, D + 10);
         if (sel <= 3)
            press_seq(1'b1, 1'b0, hold, gap, "rnd S");
         else if (sel <= 6)
            press_seq(1'b0, 1'b1, hold, gap, "rnd L");
         else if (sel == 7)
            press_seq(1'b1, 1'b1, hold, gap, "rnd SL");
         else if (sel == 8)
            press_seq(1'b1, 1'b0, $urandom_range(1, D - 1), gap, "rnd glitch S");
         else
            press_seq(1'b0, 1'b1, $urandom_range(1, D - 1), gap, "rnd glitch L");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
